burst_extract: RTL and testbench
================================

Name: burst_extract

Overview:
Downstream stage of the preamble correlator. Consumes the delay-aligned I/Q stream and the start-of-packet strobe from the correlator, and cuts a fixed-length burst starting a programmable number of samples after the strobe. The burst is buffered in an internal FIFO and presented to the demodulator on a valid/ready stream with sop/eop/err tags, so downstream back-pressure never stalls the sample-rate input.

Parameters:
DW, 12, I/Q sample width (signed)
LEN_W, 14, width of skip_len/frame_len and internal counters
FIFO_AW, 11, FIFO address width (depth 2**FIFO_AW entries, each {err,eop,sop,I,Q})

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
data_i  in  DW  signed I sample (correlator delayed output)
data_q  in  DW  signed Q sample
ival  in  1  input sample valid
isop  in  1  preamble-detect strobe, sampled only with ival=1
skip_len  in  LEN_W  samples discarded after strobe before capture
frame_len  in  LEN_W  burst length in samples, 0 treated as 1
odata_i  out  DW  burst I sample
odata_q  out  DW  burst Q sample
oval  out  1  output valid
ordy  in  1  downstream ready
osop  out  1  first sample of burst
oeop  out  1  last sample of burst
oerr  out  1  burst truncated by overflow (valid with oeop only)
busy  out  1  state != IDLE
ovf  out  1  sticky overflow flag, cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, counters 0; odata_i/q=0, oval=0, osop=0, oeop=0, oerr=0, busy=0, ovf=0.
- skip_len/frame_len latched at the isop acceptance cycle; changes during a burst have no effect.
- FSM states IDLE, SKIP, CAPT, TERM.
- IDLE: on ival&isop -> if latched skip=0, this sample is written as burst sample 0 (sop=1) and go CAPT (or write with eop=1 and stay IDLE if frame_len<=1); else cnt=1, go SKIP.
- SKIP: each ival increments cnt; when cnt==skip and ival, that sample is burst sample 0 (sop=1), go CAPT. isop ignored.
- CAPT: each ival writes a sample, idx++; sample with idx==frame_len-1 gets eop=1 and goes IDLE. isop ignored in SKIP/CAPT (no re-trigger).
- Input with ival=0 never advances counters.
- Overflow: write attempted with FIFO full -> sample dropped, ovf<=1, go TERM. TERM: on first cycle FIFO not full, write entry {err=1,eop=1,sop=0,I=0,Q=0}, go IDLE; input samples in TERM discarded, isop in TERM ignored. If the dropped sample was sop, no entry written at all and FSM returns to IDLE (nothing to terminate).
- isop on same cycle FSM returns to IDLE from CAPT/TERM: ignored.
- Output side: first-word-fall-through, registered outputs. Entry written at cycle N is visible with oval=1 at cycle N+2 earliest. Transfer on oval&ordy. While oval&!ordy all outputs hold stable. Tags osop/oeop/oerr are zero whenever oval=0.
- Simultaneous read and write on full FIFO: write is accepted (read frees slot same cycle) only if read pointer advances in that cycle; full compares pre-update pointers, so drop occurs — documented, bench must expect drop.
- Pointers wrap modulo 2**FIFO_AW with an extra MSB for full/empty.
- Sustained throughput one sample/cycle in and out with ordy=1.

Optional Feature:
Macro BURST_EXTRACT_DROP_CNT_EN. Defined: extra output drop_cnt (16 bit) counts isop strobes ignored in SKIP/CAPT/TERM plus samples dropped on overflow, saturating at 65535, reset to 0. Not defined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Ramp I=n, Q=-n, ival=1, isop at n=100, skip=5, frame=8, ordy=1 -> 8 outputs I=105..112, osop on 105, oeop on 112, oerr=0, first oval 2 cycles after I=105 written.
- skip=0, frame=1, isop at n=7 -> single output I=7 with osop=oeop=1; busy never asserted beyond acceptance cycle.
- ival toggling 1/0 during CAPT, frame=4 -> exactly 4 samples out, contiguous input-valid samples, no duplicates.
- FIFO_AW=4, frame=40, ordy=0 -> 16 entries stored, ovf=1, after ordy=1: 16 samples then next write is err/eop entry; oerr=1 with oeop.
- Second isop 3 samples into a frame=10 burst -> ignored, single 10-sample burst; with DROP_CNT_EN drop_cnt=1.
- Assert rst=0 mid-CAPT with oval=1 -> all outputs 0 immediately (async), next isop after release yields a clean burst with osop.

Source files
------------

// File: rtl/burst_extract.sv
// burst_extract: cuts a fixed-length burst out of the correlator's delay-aligned I/Q stream.
// A burst starts skip_len valid samples after an accepted isop strobe and lasts frame_len
// samples. Samples are buffered in a FIFO, so downstream back-pressure never stalls the input.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   data_i/data_q, ival  input samples and their valid
//   isop                 preamble strobe (only looked at with ival=1)
//   skip_len, frame_len  burst geometry, latched when isop is accepted (frame_len 0 acts as 1)
//   odata_i/odata_q      burst samples (FWFT, registered)
//   oval/ordy            output handshake
//   osop/oeop/oerr       burst tags; oerr marks an overflow-truncated burst (comes with oeop)
//   busy                 FSM not idle
//   ovf                  sticky overflow flag
//   drop_cnt             only with BURST_EXTRACT_DROP_CNT_EN: saturating count of ignored
//                        strobes plus samples dropped on overflow
module burst_extract #(
  parameter int unsigned DW      = 12,
  parameter int unsigned LEN_W   = 14,
  parameter int unsigned FIFO_AW = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    data_i,
  input  logic [DW-1:0]    data_q,
  input  logic             ival,
  input  logic             isop,
  input  logic [LEN_W-1:0] skip_len,
  input  logic [LEN_W-1:0] frame_len,
  output logic [DW-1:0]    odata_i,
  output logic [DW-1:0]    odata_q,
  output logic             oval,
  input  logic             ordy,
  output logic             osop,
  output logic             oeop,
  output logic             oerr,
  output logic             busy,
`ifdef BURST_EXTRACT_DROP_CNT_EN
  output logic [15:0]      drop_cnt,
`endif
  output logic             ovf
);

  localparam int unsigned EW    = 2 * DW + 3;  // {err, eop, sop, I, Q}
  localparam int unsigned Depth = 1 << FIFO_AW;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSkip = 2'd1;
  localparam logic [1:0] StCapt = 2'd2;
  localparam logic [1:0] StTerm = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] skip_q, skip_d;
  logic [LEN_W-1:0] frame_q, frame_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] frame_eff;

  logic [EW-1:0]    mem [Depth];
  logic [FIFO_AW:0] wptr_q, rptr_q, rptr_d, rptr_inc;
  logic             full, empty;
  logic             wr_req, wr_en, wr_sop, wr_eop, wr_err, drop;
  logic [EW-1:0]    wr_entry;
  logic             oval_q, oval_d;
  logic [EW-1:0]    oent_q, oent_d;

  // Extra pointer MSB distinguishes full from empty.
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign frame_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    frame_d = frame_q;
    wr_req  = 1'b0;
    wr_sop  = 1'b0;
    wr_eop  = 1'b0;
    wr_err  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ival && isop) begin
          skip_d  = skip_len;
          frame_d = frame_eff;
          if (skip_len == '0) begin
            wr_req = 1'b1;
            wr_sop = 1'b1;
            wr_eop = (frame_eff == LEN_W'(1));
            // A dropped first sample leaves nothing to terminate: stay idle.
            if (full) begin
              drop = 1'b1;
            end else if (!wr_eop) begin
              cnt_d   = LEN_W'(1);
              state_d = StCapt;
            end
          end else begin
            cnt_d   = LEN_W'(1);
            state_d = StSkip;
          end
        end
      end
      StSkip: begin
        if (ival) begin
          if (cnt_q == skip_q) begin
            wr_req = 1'b1;
            wr_sop = 1'b1;
            wr_eop = (frame_q == LEN_W'(1));
            if (full) begin
              drop    = 1'b1;
              state_d = StIdle;
            end else if (wr_eop) begin
              state_d = StIdle;
            end else begin
              cnt_d   = LEN_W'(1);
              state_d = StCapt;
            end
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      StCapt: begin
        if (ival) begin
          wr_req = 1'b1;
          wr_eop = (cnt_q == frame_q - LEN_W'(1));
          if (full) begin
            drop    = 1'b1;
            state_d = StTerm;
          end else if (wr_eop) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      StTerm: begin
        // Close the truncated burst with an err/eop marker as soon as there is room.
        if (!full) begin
          wr_req  = 1'b1;
          wr_err  = 1'b1;
          wr_eop  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    ovf_d = ovf_q | drop;
  end

  // Full is judged on pre-update pointers, so a same-cycle read does not rescue a write.
  assign wr_en    = wr_req && !full;
  assign wr_entry = wr_err ? {3'b110, {(2 * DW){1'b0}}} : {1'b0, wr_eop, wr_sop, data_i, data_q};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[FIFO_AW-1:0]] <= wr_entry;
  end

  // Output register holds mem[rptr]; rptr advances only on a completed transfer.
  assign rptr_inc = rptr_q + 1'b1;

  always_comb begin
    rptr_d = rptr_q;
    oval_d = oval_q;
    oent_d = oent_q;
    if (oval_q) begin
      if (ordy) begin
        rptr_d = rptr_inc;
        if (rptr_inc != wptr_q) begin
          oent_d = mem[rptr_inc[FIFO_AW-1:0]];
        end else begin
          oval_d = 1'b0;
          oent_d = '0;
        end
      end
    end else if (!empty) begin
      oval_d = 1'b1;
      oent_d = mem[rptr_q[FIFO_AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      skip_q  <= '0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      oval_q  <= 1'b0;
      oent_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      rptr_q  <= rptr_d;
      oval_q  <= oval_d;
      oent_q  <= oent_d;
    end
  end

`ifdef BURST_EXTRACT_DROP_CNT_EN
  logic        isop_ign;
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  // Any accepted-looking strobe outside IDLE is ignored (no re-trigger).
  assign isop_ign = ival && isop && (state_q != StIdle);
  assign drop_sum = {1'b0, drop_cnt_q} + 17'(isop_ign) + 17'(drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign odata_i = oent_q[2*DW-1:DW];
  assign odata_q = oent_q[DW-1:0];
  assign osop    = oent_q[2*DW];
  assign oeop    = oent_q[2*DW+1];
  assign oerr    = oent_q[2*DW+2];
  assign oval    = oval_q;
  assign busy    = (state_q != StIdle);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_burst_extract.sv
module tb_burst_extract;

  localparam int unsigned DW    = 12;
  localparam int unsigned LEN_W = 14;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    data_i, data_q;
  logic             ival, isop;
  logic [LEN_W-1:0] skip_len, frame_len;
  logic [DW-1:0]    odata_i, odata_q;
  logic             oval, ordy, osop, oeop, oerr, busy, ovf;
`ifdef BURST_EXTRACT_DROP_CNT_EN
  logic [15:0]      drop_cnt;
  int               drop_before;
`endif

  burst_extract #(
    .DW      (DW),
    .LEN_W   (LEN_W),
    .FIFO_AW (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .data_q    (data_q),
    .ival      (ival),
    .isop      (isop),
    .skip_len  (skip_len),
    .frame_len (frame_len),
    .odata_i   (odata_i),
    .odata_q   (odata_q),
    .oval      (oval),
    .ordy      (ordy),
    .osop      (osop),
    .oeop      (oeop),
    .oerr      (oerr),
    .busy      (busy),
`ifdef BURST_EXTRACT_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic          eop;
    logic          sop;
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } ent_t;

  ent_t obs[$];
  int   cyc = 0;
  int   first_oval;
  int   wr_cyc;
  bit   busy_seen;
  int   n_checks = 0;
  int   n_errors = 0;
  ent_t e;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers complete at the next posedge; record them mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (oval && ordy) obs.push_back({oerr, oeop, osop, odata_i, odata_q});
      if (oval && first_oval < 0) first_oval = cyc;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step(input logic v, input logic s, input int n);
    ival   = v;
    isop   = s;
    data_i = DW'(n);
    data_q = DW'(-n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    ival = 1'b0;
    isop = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Expects len entries with I = first + stride*k, Q = -I, sop on the first.
  task automatic check_burst(input string tag, input int first, input int stride,
                             input int len, input bit eop_last);
    check($sformatf("%s count", tag), obs.size(), len);
    for (int k = 0; k < len && k < obs.size(); k++) begin
      logic [DW-1:0] ei;
      logic [DW-1:0] eq;
      ei = DW'(first + stride * k);
      eq = DW'(-(first + stride * k));
      check($sformatf("%s[%0d] data", tag, k), {obs[k].i, obs[k].q}, {ei, eq});
      check($sformatf("%s[%0d] tags", tag, k), {obs[k].err, obs[k].eop, obs[k].sop},
            {1'b0, eop_last && (k == len - 1), k == 0});
    end
    obs.delete();
  endtask

  initial begin
    rst = 1'b0; ival = 1'b0; isop = 1'b0; data_i = '0; data_q = '0;
    ordy = 1'b1; skip_len = '0; frame_len = '0; first_oval = -1; wr_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {odata_i, odata_q, oval, osop, oeop, oerr, busy, ovf}, 32'd0);
    rst = 1'b1;
    idle(2);

    // Skip 5 after strobe at 100, frame 8; geometry changes mid-burst must not matter.
    skip_len = 5; frame_len = 8; first_oval = -1;
    for (int n = 90; n <= 125; n++) begin
      if (n == 102) begin skip_len = 1; frame_len = 3; end
      if (n == 105) wr_cyc = cyc;
      step(1'b1, n == 100, n);
    end
    idle(5);
    check("t1 latency", first_oval - wr_cyc, 2);
    check_burst("t1", 105, 1, 8, 1'b1);

    // Single-sample bursts: frame 1 and frame 0 (treated as 1).
    skip_len = 0; frame_len = 1; busy_seen = 1'b0;
    for (int n = 0; n <= 12; n++) step(1'b1, n == 7, n);
    idle(4);
    check("t2 busy", busy_seen, 0);
    check_burst("t2", 7, 1, 1, 1'b1);
    frame_len = 0;
    for (int n = 15; n <= 25; n++) step(1'b1, n == 20, n);
    idle(4);
    check("t2b busy", busy_seen, 0);
    check_burst("t2b", 20, 1, 1, 1'b1);

    // ival on even samples only: captured 200, 202, 204, 206.
    skip_len = 0; frame_len = 4;
    for (int n = 196; n <= 215; n++) step(n % 2 == 0, n == 200, n);
    idle(4);
    check_burst("t3", 200, 2, 4, 1'b1);

    // Overflow with ordy=0: 16 stored, 17th dropped, err/eop marker once room appears.
    ordy = 1'b0; skip_len = 0; frame_len = 40;
    for (int n = 300; n <= 340; n++) step(1'b1, n == 300, n);
    idle(2);
    check("t4 ovf", ovf, 1);
    check("t4 busy in term", busy, 1);
    check("t4 no transfers", obs.size(), 0);
    check("t4 head held", {oval, osop, odata_i}, {1'b1, 1'b1, 12'd300});
`ifdef BURST_EXTRACT_DROP_CNT_EN
    check("t4 drop_cnt", drop_cnt, 1);
`endif
    ordy = 1'b1;
    idle(25);
    check("t4 busy after", busy, 0);
    check("t4 ovf sticky", ovf, 1);
    check("t4 total", obs.size(), 17);
    if (obs.size() > 0) begin
      e = obs.pop_back();
      check("t4 term entry", e, {3'b110, 24'd0});
    end
    check_burst("t4", 300, 1, 16, 1'b0);

    // Second strobe 3 samples into a 10-sample burst is ignored.
`ifdef BURST_EXTRACT_DROP_CNT_EN
    drop_before = drop_cnt;
`endif
    skip_len = 0; frame_len = 10;
    for (int n = 400; n <= 420; n++) step(1'b1, n == 400 || n == 403, n);
    idle(4);
    check_burst("t5", 400, 1, 10, 1'b1);
`ifdef BURST_EXTRACT_DROP_CNT_EN
    check("t5 drop_cnt delta", drop_cnt - drop_before, 1);
`endif

    // Async reset mid-capture with output valid, then a clean burst.
    ordy = 1'b0; skip_len = 0; frame_len = 20;
    for (int n = 500; n <= 505; n++) step(1'b1, n == 500, n);
    check("t6 oval before reset", oval, 1);
    #2 rst = 1'b0;
    #1;
    check("t6 async reset", {odata_i, odata_q, oval, osop, oeop, oerr, busy, ovf}, 32'd0);
    ival = 1'b0; isop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; ordy = 1'b1; obs.delete();
    skip_len = 1; frame_len = 3;
    for (int n = 595; n <= 610; n++) step(1'b1, n == 600, n);
    idle(4);
    check_burst("t6", 601, 1, 3, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
